// File: rtl/timer_arb_if.sv
// Requester-side bus of the timer arbiter: one instance per requester.
// The master modport is the requester, the slave modport is the arbiter.
interface timer_arb_if #(
  parameter int ADDR_W = 20
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/timer_arb.sv
// Round-robin arbiter giving the core LSU (m0) and debug (m1) access to the timer registers.
// Build macro TIMER_ARB_ADDR_CHECK_EN: only word addresses 0x00/0x04 reach the timer, others return err.
module timer_arb #(
  parameter int ADDR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  timer_arb_if.slave        m0,
  timer_arb_if.slave        m1,
  output logic              timer_wr_en_o,
  output logic [ADDR_W-1:0] timer_wr_addr_o,
  output logic [31:0]       timer_wr_data_o,
  output logic              timer_rd_en_o,
  output logic [ADDR_W-1:0] timer_rd_addr_o,
  input  logic [31:0]       timer_rd_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic              last_m1_q;
  logic              lat_id_q;
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [31:0]       lat_wdata_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;
  logic              gnt0;
  logic              gnt1;
  logic              addr_ok;
  logic              resp_phase;

`ifdef TIMER_ARB_ADDR_CHECK_EN
  assign addr_ok = (lat_addr_q == '0) || (lat_addr_q == ADDR_W'(4));
`else
  assign addr_ok = 1'b1;
`endif

  // Grants are gated by rst_ni so nothing is accepted while reset is held.
  always_comb begin
    state_d         = state_q;
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    timer_wr_en_o   = 1'b0;
    timer_wr_addr_o = '0;
    timer_wr_data_o = '0;
    timer_rd_en_o   = 1'b0;
    timer_rd_addr_o = '0;
    case (state_q)
      IDLE: begin
        if (rst_ni) begin
          gnt0 = m0.req & (~m1.req | last_m1_q);
          gnt1 = m1.req & (~m0.req | ~last_m1_q);
          if (gnt0 || gnt1) state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (addr_ok) begin
          if (lat_we_q) begin
            timer_wr_en_o   = 1'b1;
            timer_wr_addr_o = lat_addr_q;
            timer_wr_data_o = lat_wdata_q;
          end else begin
            timer_rd_en_o   = 1'b1;
            timer_rd_addr_o = lat_addr_q;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_m1_q   <= 1'b1;
      lat_id_q    <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt0 || gnt1) begin
        last_m1_q   <= gnt1;
        lat_id_q    <= gnt1;
        lat_we_q    <= gnt1 ? m1.we    : m0.we;
        lat_addr_q  <= gnt1 ? m1.addr  : m0.addr;
        lat_wdata_q <= gnt1 ? m1.wdata : m0.wdata;
      end
      if (state_q == ACCESS) begin
        resp_data_q <= (!lat_we_q && addr_ok) ? timer_rd_data_i : 32'd0;
        resp_err_q  <= ~addr_ok;
      end
    end
  end

  // Response fields are masked so they read as zero outside the rvalid pulse.
  assign resp_phase = (state_q == RESP);
  assign m0.gnt     = gnt0;
  assign m1.gnt     = gnt1;
  assign m0.rvalid  = resp_phase & ~lat_id_q;
  assign m1.rvalid  = resp_phase & lat_id_q;
  assign m0.rdata   = m0.rvalid ? resp_data_q : 32'd0;
  assign m1.rdata   = m1.rvalid ? resp_data_q : 32'd0;
  assign m0.err     = m0.rvalid & resp_err_q;
  assign m1.err     = m1.rvalid & resp_err_q;

endmodule

// File: tb/tb_timer_arb.sv
// Bench for timer_arb: directed scenarios then random traffic, all checked against a
// transaction-schedule model (grant at N, strobe at N+1, response at N+2, next grant from N+3).
module tb_timer_arb;
  localparam int ADDR_W = 20;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              timer_wr_en_o;
  logic [ADDR_W-1:0] timer_wr_addr_o;
  logic [31:0]       timer_wr_data_o;
  logic              timer_rd_en_o;
  logic [ADDR_W-1:0] timer_rd_addr_o;
  logic [31:0]       timer_rd_data_i;
  logic [31:0]       read_value = 32'd0;

  timer_arb_if #(.ADDR_W(ADDR_W)) m0_bus ();
  timer_arb_if #(.ADDR_W(ADDR_W)) m1_bus ();

  // The timer returns garbage when not strobed so a mistimed capture shows up.
  assign timer_rd_data_i = timer_rd_en_o ? read_value : 32'hDEAD_BEEF;

  always #5 clk_i = ~clk_i;

  timer_arb #(.ADDR_W(ADDR_W)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .m0              (m0_bus),
    .m1              (m1_bus),
    .timer_wr_en_o   (timer_wr_en_o),
    .timer_wr_addr_o (timer_wr_addr_o),
    .timer_wr_data_o (timer_wr_data_o),
    .timer_rd_en_o   (timer_rd_en_o),
    .timer_rd_addr_o (timer_rd_addr_o),
    .timer_rd_data_i (timer_rd_data_i)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic              want_rst;
  logic              want_req [2];
  logic              want_we [2];
  logic [ADDR_W-1:0] want_addr [2];
  logic [31:0]       want_wdata [2];
  logic [31:0]       directed_read;
  bit                random_mode;
  bit                continuous_mode;

  int                cyc;
  int                next_free;
  int                grant_cyc;
  bit                last_m1;
  bit                txn_valid;
  bit                txn_id;
  bit                txn_we;
  bit                txn_ok;
  logic [ADDR_W-1:0] txn_addr;
  logic [31:0]       txn_wdata;
  logic [31:0]       txn_rdata;
  bit                model_gnt [2];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, observed, expected);
    end
  endtask

  task automatic new_txn(input int x);
    want_req[x]   = 1'b1;
    want_we[x]    = 1'($urandom_range(0, 1));
    want_wdata[x] = $urandom;
    case ($urandom_range(0, 4))
      0:       want_addr[x] = ADDR_W'(0);
      1:       want_addr[x] = ADDR_W'(4);
      2:       want_addr[x] = ADDR_W'(8);
      3:       want_addr[x] = ADDR_W'(2);
      default: want_addr[x] = ADDR_W'($urandom);
    endcase
  endtask

  // Requesters react to last cycle's grant, then the new inputs are driven.
  task automatic applyStimulus();
    for (int x = 0; x < 2; x++) begin
      if (model_gnt[x]) begin
        if (continuous_mode) new_txn(x);
        else want_req[x] = 1'b0;
      end
      if (random_mode) begin
        if (want_req[x] && !model_gnt[x]) begin
          if ($urandom_range(0, 15) == 0) want_req[x] = 1'b0;
        end else if (!want_req[x] && $urandom_range(0, 2) == 0) begin
          new_txn(x);
        end
      end
    end
    read_value    = random_mode ? $urandom : directed_read;
    rst_ni        = want_rst;
    m0_bus.req    = want_req[0];
    m0_bus.we     = want_we[0];
    m0_bus.addr   = want_addr[0];
    m0_bus.wdata  = want_wdata[0];
    m1_bus.req    = want_req[1];
    m1_bus.we     = want_we[1];
    m1_bus.addr   = want_addr[1];
    m1_bus.wdata  = want_wdata[1];
  endtask

  task automatic checkOutput();
    logic              exp_gnt [2];
    logic              exp_rv [2];
    logic [31:0]       exp_rdata [2];
    logic              exp_err [2];
    logic              exp_wr_en;
    logic              exp_rd_en;
    logic [ADDR_W-1:0] exp_wr_addr;
    logic [ADDR_W-1:0] exp_rd_addr;
    logic [31:0]       exp_wr_data;
    bit                winner;
    exp_gnt   = '{1'b0, 1'b0};
    exp_rv    = '{1'b0, 1'b0};
    exp_rdata = '{32'd0, 32'd0};
    exp_err   = '{1'b0, 1'b0};
    exp_wr_en = 1'b0;
    exp_rd_en = 1'b0;
    exp_wr_addr = '0;
    exp_rd_addr = '0;
    exp_wr_data = '0;
    model_gnt = '{1'b0, 1'b0};
    if (!rst_ni) begin
      txn_valid = 1'b0;
      next_free = 0;
      last_m1   = 1'b1;
    end else begin
      if (txn_valid && cyc == grant_cyc + 1 && txn_ok) begin
        if (txn_we) begin
          exp_wr_en   = 1'b1;
          exp_wr_addr = txn_addr;
          exp_wr_data = txn_wdata;
        end else begin
          exp_rd_en   = 1'b1;
          exp_rd_addr = txn_addr;
          txn_rdata   = read_value;
        end
      end
      if (txn_valid && cyc == grant_cyc + 2) begin
        exp_rv[txn_id]    = 1'b1;
        exp_rdata[txn_id] = txn_rdata;
        exp_err[txn_id]   = !txn_ok;
        txn_valid         = 1'b0;
      end
      if (cyc >= next_free && (m0_bus.req || m1_bus.req)) begin
        winner            = (m0_bus.req && m1_bus.req) ? !last_m1 : m1_bus.req;
        exp_gnt[winner]   = 1'b1;
        model_gnt[winner] = 1'b1;
        last_m1           = winner;
        txn_valid         = 1'b1;
        grant_cyc         = cyc;
        next_free         = cyc + 3;
        txn_id            = winner;
        txn_we            = winner ? m1_bus.we : m0_bus.we;
        txn_addr          = winner ? m1_bus.addr : m0_bus.addr;
        txn_wdata         = winner ? m1_bus.wdata : m0_bus.wdata;
        txn_rdata         = 32'd0;
        txn_ok            = 1'b1;
`ifdef TIMER_ARB_ADDR_CHECK_EN
        txn_ok = (txn_addr == '0) || (txn_addr == ADDR_W'(4));
`endif
      end
    end
    check("m0_gnt", m0_bus.gnt, exp_gnt[0]);
    check("m1_gnt", m1_bus.gnt, exp_gnt[1]);
    check("m0_rvalid", m0_bus.rvalid, exp_rv[0]);
    check("m1_rvalid", m1_bus.rvalid, exp_rv[1]);
    check("m0_rdata", m0_bus.rdata, exp_rdata[0]);
    check("m1_rdata", m1_bus.rdata, exp_rdata[1]);
    check("m0_err", m0_bus.err, exp_err[0]);
    check("m1_err", m1_bus.err, exp_err[1]);
    check("timer_wr_en", timer_wr_en_o, exp_wr_en);
    check("timer_wr_addr", timer_wr_addr_o, exp_wr_addr);
    check("timer_wr_data", timer_wr_data_o, exp_wr_data);
    check("timer_rd_en", timer_rd_en_o, exp_rd_en);
    check("timer_rd_addr", timer_rd_addr_o, exp_rd_addr);
    cyc++;
  endtask

  task automatic stepCycle();
    @(negedge clk_i);
    applyStimulus();
    #1;
    checkOutput();
  endtask

  task automatic set_req(input int x, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wdata);
    want_req[x]   = 1'b1;
    want_we[x]    = we;
    want_addr[x]  = addr;
    want_wdata[x] = wdata;
  endtask

  initial begin
    want_rst        = 1'b0;
    want_req        = '{1'b0, 1'b0};
    want_we         = '{1'b0, 1'b0};
    want_addr       = '{'0, '0};
    want_wdata      = '{32'd0, 32'd0};
    directed_read   = 32'd0;
    random_mode     = 1'b0;
    continuous_mode = 1'b0;
    cyc             = 0;
    next_free       = 0;
    grant_cyc       = 0;
    last_m1         = 1'b1;
    txn_valid       = 1'b0;
    txn_id          = 1'b0;
    txn_we          = 1'b0;
    txn_ok          = 1'b1;
    txn_addr        = '0;
    txn_wdata       = 32'd0;
    txn_rdata       = 32'd0;
    model_gnt       = '{1'b0, 1'b0};
    m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.wdata = 32'd0;
    m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.wdata = 32'd0;

    // Reset held with a request pending: everything must stay quiet.
    set_req(1, 1'b0, ADDR_W'(0), 32'd0);
    repeat (2) stepCycle();
    want_req[1] = 1'b0;
    stepCycle();

    // Lone m0 write of 0x100 to 0x04, granted in the first cycle after release.
    want_rst = 1'b1;
    set_req(0, 1'b1, ADDR_W'(4), 32'h0000_0100);
    repeat (4) stepCycle();

    // Lone m1 read of 0x00 with the timer returning 0xABC.
    directed_read = 32'h0000_0ABC;
    set_req(1, 1'b0, ADDR_W'(0), 32'd0);
    repeat (4) stepCycle();

    // m0 read of 0x08: forwarded normally, or rejected with err when address checking is built in.
    directed_read = 32'h1234_5678;
    set_req(0, 1'b0, ADDR_W'(8), 32'd0);
    repeat (4) stepCycle();

    // Both requesting back to back right after a reset: grants alternate m0,m1 every 3 cycles.
    want_rst = 1'b0;
    repeat (2) stepCycle();
    want_rst        = 1'b1;
    continuous_mode = 1'b1;
    set_req(0, 1'b1, ADDR_W'(4), 32'hA0A0_0001);
    set_req(1, 1'b0, ADDR_W'(0), 32'd0);
    repeat (13) stepCycle();
    continuous_mode = 1'b0;
    want_req        = '{1'b0, 1'b0};
    repeat (4) stepCycle();

    // Reset in the ACCESS cycle of an m0 write aborts it; m1 is then served normally.
    set_req(0, 1'b1, ADDR_W'(4), 32'hCAFE_0004);
    stepCycle();
    stepCycle();
    #2;
    rst_ni   = 1'b0;
    want_rst = 1'b0;
    #1;
    check("abort_wr_en", timer_wr_en_o, 1'b0);
    check("abort_wr_addr", timer_wr_addr_o, 32'd0);
    check("abort_m0_rvalid", m0_bus.rvalid, 1'b0);
    want_req[0] = 1'b0;
    set_req(1, 1'b0, ADDR_W'(4), 32'd0);
    directed_read = 32'h0000_5555;
    stepCycle();
    want_rst = 1'b1;
    repeat (5) stepCycle();

    // Random traffic with drops, illegal addresses and changing timer data.
    random_mode = 1'b1;
    repeat (400) stepCycle();
    random_mode = 1'b0;
    want_req    = '{1'b0, 1'b0};
    repeat (4) stepCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
